// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage behind the 8x16 register file.
// Single-cycle ALU ops register their write-back strobe one edge after
// acceptance. MUL runs as an iterative shift-add and stalls issue until done.
module alu_exec_stage #(
  parameter bit MUL_EN     = 1'b1,
  parameter int MUL_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  opcode,
  input  logic [2:0]  dest,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [3:0]  flags,
  output logic        busy
);

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_SAR = 4'h9;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  localparam logic [4:0] MUL_CNT = 5'(MUL_CYCLES);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  // N and Z of a 16-bit result, packed as {N,Z}
  function automatic logic [1:0] nz_of(input logic [15:0] v);
    return {v[15], (v == 16'h0000)};
  endfunction

  state_t      state_r;
  logic        ready_r;
  logic        busy_r;
  logic        wb_en_r;
  logic [2:0]  wb_addr_r;
  logic [15:0] wb_data_r;
  logic [3:0]  flags_r;
  logic [31:0] acc_r;
  logic [31:0] mcand_r;
  logic [15:0] mplier_r;
  logic [4:0]  cnt_r;
  logic [2:0]  mdest_r;

  logic [16:0] add_s;
  logic [16:0] sub_s;
  logic [16:0] shl_s;
  logic [16:0] shr_s;
  logic [16:0] sar_s;
  logic [15:0] res_s;
  logic        c_s;
  logic        v_s;
  logic        upd_s;
  logic        wr_s;
  logic        is_mul_s;
  logic [31:0] acc_next_s;

  // Shifts carry one extra bit so the last bit shifted out lands in the spare position
  assign add_s = {1'b0, op_a} + {1'b0, op_b};
  assign sub_s = {1'b0, op_a} - {1'b0, op_b};
  assign shl_s = {1'b0, op_a} << op_b[3:0];
  assign shr_s = {op_a, 1'b0} >> op_b[3:0];
  assign sar_s = 17'($signed({op_a, 1'b0}) >>> op_b[3:0]);

  assign is_mul_s   = MUL_EN && (opcode == OP_MUL);
  assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : 32'h0000_0000);

  // Single-cycle result, carry/overflow and write/flag-update qualifiers per opcode
  always_comb begin
    res_s = 16'h0000;
    c_s   = 1'b0;
    v_s   = 1'b0;
    upd_s = 1'b0;
    wr_s  = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_s = add_s[15:0];
        c_s   = add_s[16];
        v_s   = (op_a[15] == op_b[15]) && (add_s[15] != op_a[15]);
        upd_s = 1'b1;
        wr_s  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        res_s = sub_s[15:0];
        c_s   = sub_s[16];
        v_s   = (op_a[15] != op_b[15]) && (sub_s[15] != op_a[15]);
        upd_s = 1'b1;
        wr_s  = (opcode == OP_SUB);
      end
      OP_AND: begin res_s = op_a & op_b; upd_s = 1'b1; wr_s = 1'b1; end
      OP_OR:  begin res_s = op_a | op_b; upd_s = 1'b1; wr_s = 1'b1; end
      OP_XOR: begin res_s = op_a ^ op_b; upd_s = 1'b1; wr_s = 1'b1; end
      OP_NOT: begin res_s = ~op_a;       upd_s = 1'b1; wr_s = 1'b1; end
      OP_SHL: begin res_s = shl_s[15:0]; c_s = shl_s[16]; upd_s = 1'b1; wr_s = 1'b1; end
      OP_SHR: begin res_s = shr_s[16:1]; c_s = shr_s[0];  upd_s = 1'b1; wr_s = 1'b1; end
      OP_SAR: begin res_s = sar_s[16:1]; c_s = sar_s[0];  upd_s = 1'b1; wr_s = 1'b1; end
      OP_MOV: begin res_s = op_b;        upd_s = 1'b1; wr_s = 1'b1; end
      default: begin
        // NOP, MUL (sequenced separately) and reserved opcodes: nothing to do
        res_s = 16'h0000;
        upd_s = 1'b0;
        wr_s  = 1'b0;
      end
    endcase
  end

  // IDLE/MUL sequencer with registered write-back, flags and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      wb_en_r   <= 1'b0;
      wb_addr_r <= 3'd0;
      wb_data_r <= 16'h0000;
      flags_r   <= 4'h0;
      acc_r     <= 32'h0000_0000;
      mcand_r   <= 32'h0000_0000;
      mplier_r  <= 16'h0000;
      cnt_r     <= 5'd0;
      mdest_r   <= 3'd0;
    end else begin
      wb_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_valid && is_mul_s) begin
            mcand_r  <= {16'h0000, op_a};
            mplier_r <= op_b;
            acc_r    <= 32'h0000_0000;
            cnt_r    <= MUL_CNT;
            mdest_r  <= dest;
            state_r  <= ST_MUL;
            busy_r   <= 1'b1;
            ready_r  <= 1'b0;
          end else if (issue_valid) begin
            wb_en_r <= wr_s;
            if (wr_s) begin
              wb_addr_r <= dest;
              wb_data_r <= res_s;
            end
            if (upd_s) begin
              flags_r <= {nz_of(res_s), c_s, v_s};
            end
          end
        end
        ST_MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            wb_en_r   <= 1'b1;
            wb_addr_r <= mdest_r;
            wb_data_r <= acc_next_s[15:0];
            flags_r   <= {nz_of(acc_next_s[15:0]), (acc_next_s[31:16] != 16'h0000), 1'b0};
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign issue_ready = ready_r;
  assign busy        = busy_r;
  assign wb_en       = wb_en_r;
  assign wb_addr     = wb_addr_r;
  assign wb_data     = wb_data_r;
  assign flags       = flags_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (plus a MUL_EN=0 instance).
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        nm_valid;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic        issue_ready, wb_en, busy;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  flags;

  logic        nm_ready, nm_wb_en, nm_busy;
  logic [2:0]  nm_wb_addr;
  logic [15:0] nm_wb_data;
  logic [3:0]  nm_flags;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_stage #(.MUL_EN(1'b1), .MUL_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .dest(dest), .op_a(op_a), .op_b(op_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags), .busy(busy)
  );

  alu_exec_stage #(.MUL_EN(1'b0), .MUL_CYCLES(16)) dut_nm (
    .clk(clk), .rst_n(rst_n), .issue_valid(nm_valid), .issue_ready(nm_ready),
    .opcode(opcode), .dest(dest), .op_a(op_a), .op_b(op_b),
    .wb_en(nm_wb_en), .wb_addr(nm_wb_addr), .wb_data(nm_wb_data), .flags(nm_flags), .busy(nm_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op, let one edge accept it, then drop valid
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    opcode = op; op_a = a; op_b = b; dest = d; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic wb_chk(input string tag, input logic [2:0] a, input logic [15:0] d,
                        input logic [3:0] f);
    chk({tag, ".wb_en"},   32'(wb_en),   32'd1);
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(a));
    chk({tag, ".wb_data"}, 32'(wb_data), 32'(d));
    chk({tag, ".flags"},   32'(flags),   32'(f));
  endtask

  initial begin
    int  cyc;
    logic saw_wb;
    logic [3:0] flags_prev;

    rst_n = 1'b0; issue_valid = 1'b0; nm_valid = 1'b0;
    opcode = 4'h0; dest = 3'd0; op_a = 16'h0000; op_b = 16'h0000;

    #2;
    chk("rst.wb_en",   32'(wb_en),   32'd0);
    chk("rst.wb_addr", 32'(wb_addr), 32'd0);
    chk("rst.wb_data", 32'(wb_data), 32'd0);
    chk("rst.flags",   32'(flags),   32'd0);
    chk("rst.busy",    32'(busy),    32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready", 32'(issue_ready), 32'd1);

    // ADD signed overflow
    issue(4'h1, 16'h7FFF, 16'h0001, 3'd3);
    wb_chk("add_ovf", 3'd3, 16'h8000, 4'b1001);
    chk("add_ovf.ready", 32'(issue_ready), 32'd1);
    @(posedge clk); #1;
    chk("add_ovf.pulse_end", 32'(wb_en), 32'd0);

    // Back-to-back SUB, XOR, CMP
    issue(4'h2, 16'h0005, 16'h0005, 3'd1);
    wb_chk("b2b_sub", 3'd1, 16'h0000, 4'b0100);
    issue(4'h5, 16'hFF00, 16'h0FF0, 3'd2);
    wb_chk("b2b_xor", 3'd2, 16'hF0F0, 4'b1000);
    issue(4'hB, 16'h0001, 16'h0002, 3'd4);
    chk("b2b_cmp.wb_en", 32'(wb_en), 32'd0);
    chk("b2b_cmp.flags", 32'(flags), 32'(4'b1010));

    // Shifts
    issue(4'h7, 16'h8001, 16'h0001, 3'd4);
    wb_chk("shl", 3'd4, 16'h0002, 4'b0010);
    issue(4'h9, 16'h8000, 16'h000F, 3'd5);
    wb_chk("sar", 3'd5, 16'hFFFF, 4'b1000);
    issue(4'h8, 16'h1234, 16'h0000, 3'd6);
    wb_chk("shr0", 3'd6, 16'h1234, 4'b0000);
    issue(4'h8, 16'h0003, 16'h0001, 3'd6);
    wb_chk("shr1", 3'd6, 16'h0001, 4'b0010);

    // Remaining single-cycle ops and carry/borrow corners
    issue(4'h1, 16'hFFFF, 16'h0001, 3'd0);
    wb_chk("add_carry", 3'd0, 16'h0000, 4'b0110);
    issue(4'h2, 16'h8000, 16'h0001, 3'd1);
    wb_chk("sub_ovf", 3'd1, 16'h7FFF, 4'b0001);
    issue(4'h2, 16'h0001, 16'h0002, 3'd2);
    wb_chk("sub_borrow", 3'd2, 16'hFFFF, 4'b1010);
    issue(4'h3, 16'hF0F0, 16'h0FF0, 3'd3);
    wb_chk("and", 3'd3, 16'h00F0, 4'b0000);
    issue(4'h4, 16'h8000, 16'h0001, 3'd4);
    wb_chk("or", 3'd4, 16'h8001, 4'b1000);
    issue(4'h6, 16'hFFFF, 16'h1234, 3'd5);
    wb_chk("not", 3'd5, 16'h0000, 4'b0100);
    issue(4'hA, 16'h1111, 16'h8000, 3'd6);
    wb_chk("mov", 3'd6, 16'h8000, 4'b1000);

    // Reserved opcode and NOP leave flags alone
    flags_prev = 4'b1000;
    issue(4'hE, 16'($urandom), 16'($urandom), 3'd2);
    chk("resv.wb_en", 32'(wb_en), 32'd0);
    chk("resv.flags", 32'(flags), 32'(flags_prev));
    issue(4'h0, 16'($urandom), 16'($urandom), 3'd3);
    chk("nop.wb_en", 32'(wb_en), 32'd0);
    chk("nop.flags", 32'(flags), 32'(flags_prev));

    // MUL with an ADD waiting behind it
    issue(4'hC, 16'h0123, 16'h0100, 3'd7);
    chk("mul.busy", 32'(busy), 32'd1);
    opcode = 4'h1; op_a = 16'h0002; op_b = 16'h0003; dest = 3'd5; issue_valid = 1'b1;
    cyc = 0; saw_wb = 1'b0;
    while (!issue_ready && cyc < 40) begin
      cyc++;
      if (wb_en) saw_wb = 1'b1;
      @(posedge clk); #1;
    end
    chk("mul.stall_cycles", 32'(cyc), 32'd16);
    chk("mul.no_early_wb", 32'(saw_wb), 32'd0);
    wb_chk("mul", 3'd7, 16'h2300, 4'b0010);
    chk("mul.busy_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    wb_chk("mul_then_add", 3'd5, 16'h0005, 4'b0000);

    // Reset in the middle of a MUL
    issue(4'hC, 16'h00FF, 16'h0003, 3'd6);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst.busy",  32'(busy),  32'd0);
    chk("midrst.flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    saw_wb = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (wb_en) saw_wb = 1'b1; end
    chk("midrst.no_wb", 32'(saw_wb),      32'd0);
    chk("midrst.ready", 32'(issue_ready), 32'd1);
    chk("midrst.busy2", 32'(busy),        32'd0);
    chk("midrst.flags2", 32'(flags),      32'd0);

    // MUL_EN=0: MUL is a NOP
    opcode = 4'hC; op_a = 16'h0003; op_b = 16'h0004; dest = 3'd1; nm_valid = 1'b1;
    @(posedge clk); #1;
    nm_valid = 1'b0;
    chk("nomul.wb_en", 32'(nm_wb_en), 32'd0);
    chk("nomul.ready", 32'(nm_ready), 32'd1);
    chk("nomul.busy",  32'(nm_busy),  32'd0);
    chk("nomul.flags", 32'(nm_flags), 32'd0);
    @(posedge clk); #1;
    chk("nomul.wb_en2", 32'(nm_wb_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
